multich_rate_adapter: RTL and testbench

//  Multi-channel rate adapter. Takes packed CH-channel frames at the 48 kHz base rate and emits frames at a rate

---
 rtl/rate_adapter_pkg.sv | 24 ++
 rtl/rate_strobe_gen.sv | 74 +++++++
 rtl/multich_rate_adapter.sv | 143 ++++++++++++++
 tb/tb_multich_rate_adapter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_adapter_pkg.sv
// Shared rate codes and period helper for the multi-channel rate adapter.
package rate_adapter_pkg;

  localparam logic [2:0] RATE_1536K = 3'd0;
  localparam logic [2:0] RATE_768K  = 3'd1;
  localparam logic [2:0] RATE_384K  = 3'd2;
  localparam logic [2:0] RATE_192K  = 3'd3;
  localparam logic [2:0] RATE_96K   = 3'd4;
  localparam logic [2:0] RATE_48K   = 3'd5;
  localparam logic [2:0] RATE_24K   = 3'd6;
  localparam logic [2:0] RATE_12K   = 3'd7;

  // Code that selects the unmodified 48 kHz base rate.
  localparam logic [2:0] RATE_BASE  = RATE_48K;

  // The fastest rate (code 0) has an 8-cycle output period.
  localparam int unsigned PERIOD_LOG2_MIN = 3;

  // log2 of the output period P, in sample_clk cycles, for a rate code.
  function automatic logic [3:0] period_log2(input logic [2:0] rate);
    return {1'b0, rate} + 4'(PERIOD_LOG2_MIN);
  endfunction

endpackage

// File: rtl/rate_strobe_gen.sv
// Timing core: free-running base-period counter, output strobes for the
// selected rate, decimation counter and rate-change handling.
module rate_strobe_gen #(
  parameter int unsigned BASE_PERIOD  = 256,
  parameter int unsigned RATE_BASE    = 5,
  parameter int unsigned MAX_DEC_LOG2 = 2
) (
  input  logic       sample_clk,
  input  logic       reset_n,
  input  logic [2:0] rate_sel,
  output logic       base_tick,
  output logic       out_tick,
  output logic       phase_zero,
  output logic       up_mode,
  output logic       down_mode,
  output logic       dec_last,
  output logic       rate_apply,
  output logic       resync,
  output logic [2:0] dec_log2
);
  import rate_adapter_pkg::*;

  localparam int unsigned CW        = $clog2(BASE_PERIOD);
  localparam logic [2:0]  BASE_CODE = 3'(RATE_BASE);

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           p_mask;
  logic [2:0]              rate_q;
  logic [MAX_DEC_LOG2-1:0] dec_cnt;
  logic [MAX_DEC_LOG2-1:0] dec_max;
  logic [3:0]              p_log2;
  logic                    pending;
  logic                    raw_tick;

  // Decode strobes from the counter and the applied rate; a pending rate
  // change masks every output strobe until it is applied at base_tick.
  always_comb begin
    base_tick  = (cnt == '1);
    up_mode    = (rate_q < BASE_CODE);
    down_mode  = (rate_q > BASE_CODE);
    p_log2     = period_log2(rate_q);
    p_mask     = '1;
    if (up_mode) p_mask = CW'((32'd1 << p_log2) - 32'd1);
    phase_zero = ((cnt >> p_log2) == '0);
    dec_log2   = down_mode ? (rate_q - BASE_CODE) : 3'd0;
    dec_max    = {MAX_DEC_LOG2{1'b1}} >> (3'(MAX_DEC_LOG2) - dec_log2);
    dec_last   = down_mode && (dec_cnt == dec_max);
    pending    = (rate_sel != rate_q);
    rate_apply = base_tick && pending;
    if (up_mode)        raw_tick = ((cnt & p_mask) == p_mask);
    else if (down_mode) raw_tick = base_tick && dec_last;
    else                raw_tick = base_tick;
    out_tick   = raw_tick && !pending;
  end

  // Counter, rate latch (base_tick only), decimation count and resync pulse.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      rate_q  <= '0;
      dec_cnt <= '0;
      resync  <= 1'b0;
    end else begin
      cnt    <= cnt + CW'(1);
      resync <= rate_apply;
      if (base_tick) begin
        rate_q <= rate_sel;
        if (rate_apply || !down_mode || dec_last) dec_cnt <= '0;
        else                                      dec_cnt <= dec_cnt + MAX_DEC_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/multich_rate_adapter.sv
// Multi-channel rate adapter: one-frame input skid slot, base-rate hold
// register, and per-channel up-rate (zero-stuff/hold) or down-rate
// (drop/block-average) output selection, all on sample_clk.
module multich_rate_adapter #(
  parameter int unsigned CH           = 2,
  parameter int unsigned SW           = 16,
  parameter int unsigned BASE_PERIOD  = 256,
  parameter int unsigned RATE_BASE    = 5,
  parameter int unsigned MAX_DEC_LOG2 = 2
) (
  input  logic             sample_clk,
  input  logic             reset_n,
  input  logic [2:0]       rate_sel,
  input  logic             avg_mode,
  input  logic             hold_mode,
  input  logic [CH*SW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CH*SW-1:0] out_data,
  output logic             out_valid,
  output logic             underrun,
  output logic             resync
);
  import rate_adapter_pkg::*;

  localparam int unsigned AW = SW + MAX_DEC_LOG2;

  logic [CH*SW-1:0] slot;
  logic [CH*SW-1:0] hold;
  logic [CH*SW-1:0] hold_next;
  logic [CH*SW-1:0] out_next;
  logic             slot_full;
  logic             consume;
  logic             fill;

  logic       base_tick;
  logic       out_tick;
  logic       phase_zero;
  logic       up_mode;
  logic       down_mode;
  logic       dec_last;
  logic       rate_apply;
  logic [2:0] dec_log2;

  rate_strobe_gen #(
    .BASE_PERIOD  (BASE_PERIOD),
    .RATE_BASE    (RATE_BASE),
    .MAX_DEC_LOG2 (MAX_DEC_LOG2)
  ) u_strobe (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .rate_sel   (rate_sel),
    .base_tick  (base_tick),
    .out_tick   (out_tick),
    .phase_zero (phase_zero),
    .up_mode    (up_mode),
    .down_mode  (down_mode),
    .dec_last   (dec_last),
    .rate_apply (rate_apply),
    .resync     (resync),
    .dec_log2   (dec_log2)
  );

  // Skid-slot handshake; the slot may drain and refill in the same cycle.
  always_comb begin
    consume   = base_tick && slot_full;
    in_ready  = !slot_full || consume;
    fill      = in_valid && in_ready;
    hold_next = slot_full ? slot : '0;
  end

  // Input skid slot.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot      <= '0;
      slot_full <= 1'b0;
    end else begin
      if (fill) slot <= in_data;
      if (fill)         slot_full <= 1'b1;
      else if (consume) slot_full <= 1'b0;
    end
  end

  // Base-rate hold register; an empty slot at base_tick holds silence and
  // latches underrun until reset.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold     <= '0;
      underrun <= 1'b0;
    end else if (base_tick) begin
      hold <= hold_next;
      if (!slot_full) underrun <= 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_c;
    logic [SW-1:0]        hold_ch;
    logic [SW-1:0]        next_ch;
    logic [SW-1:0]        avg_ch;
    logic [SW-1:0]        sel_ch;

    // Running block sum includes the frame entering hold this tick, so the
    // block's last frame is averaged in on the same tick the sum is cleared.
    always_comb begin
      hold_ch = hold[c*SW +: SW];
      next_ch = hold_next[c*SW +: SW];
      acc_c   = acc_q + $signed({{MAX_DEC_LOG2{next_ch[SW-1]}}, next_ch});
      avg_ch  = SW'(acc_c >>> dec_log2);
      sel_ch  = hold_ch;
      if (up_mode) begin
        if (!phase_zero && !hold_mode) sel_ch = '0;
      end else if (down_mode) begin
        sel_ch = avg_mode ? avg_ch : next_ch;
      end
    end

    assign out_next[c*SW +: SW] = sel_ch;

    // Accumulate inside a decimation block; clear on block end or rate change.
    always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q <= '0;
      end else if (base_tick) begin
        if (down_mode && !rate_apply && !dec_last) acc_q <= acc_c;
        else                                       acc_q <= '0;
      end
    end
  end

  // Registered output strobe; out_data holds between strobes.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_tick;
      if (out_tick) out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_multich_rate_adapter.sv
// Directed bench for multich_rate_adapter (CH=2, SW=16, 256-cycle base frame).
module tb_multich_rate_adapter;
  import rate_adapter_pkg::*;

  logic        sample_clk = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  rate_sel   = RATE_48K;
  logic        avg_mode   = 1'b0;
  logic        hold_mode  = 1'b0;
  logic [31:0] in_data    = '0;
  logic        in_valid   = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        underrun;
  logic        resync;

  int n_checks = 0;
  int n_pass   = 0;

  int          stat_n;
  int          stat_first;
  int          stat_last;
  int          stat_other_bad;
  int          stat_resync;
  int          stat_resync_at;
  logic [31:0] stat_first_data;

  multich_rate_adapter #(
    .CH           (2),
    .SW           (16),
    .BASE_PERIOD  (256),
    .RATE_BASE    (5),
    .MAX_DEC_LOG2 (2)
  ) dut (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .rate_sel   (rate_sel),
    .avg_mode   (avg_mode),
    .hold_mode  (hold_mode),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .underrun   (underrun),
    .resync     (resync)
  );

  always #5 sample_clk = ~sample_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] frame_of(input int k);
    return {16'h1000 + 16'(k), 16'hF000 - 16'(k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge sample_clk);
  endtask

  // Run n cycles from a negedge, optionally offering one frame on the first
  // cycle, and gather strobe/resync statistics (indices are 1-based cycles).
  task automatic run_period(input int n, input logic give, input logic [31:0] frame,
                            input logic [31:0] other_exp);
    stat_n = 0; stat_first = 0; stat_last = 0; stat_other_bad = 0;
    stat_resync = 0; stat_resync_at = 0; stat_first_data = '0;
    in_valid = give;
    in_data  = frame;
    for (int i = 1; i <= n; i++) begin
      @(negedge sample_clk);
      if (i == 1) in_valid = 1'b0;
      if (out_valid) begin
        stat_n++;
        if (stat_n == 1) begin
          stat_first      = i;
          stat_first_data = out_data;
        end else if (out_data !== other_exp) begin
          stat_other_bad++;
        end
        stat_last = i;
      end
      if (resync) begin
        stat_resync++;
        stat_resync_at = i;
      end
    end
  endtask

  initial begin
    int          acc_cnt;
    int          low_cnt;
    int          outs;
    logic        take;
    logic [31:0] exp_seq;

    // ---------------- T1: reset, then mid-frame reset ----------------
    repeat (3) @(negedge sample_clk);
    reset_n = 1'b1;
    run_period(256, 1'b1, 32'hCAFE_0123, 32'h0);
    chk("t1_apply_no_valid", stat_n, 0);
    chk("t1_apply_resync_at", stat_resync_at, 256);
    chk("t1_no_underrun_yet", underrun, 1'b0);
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t1_pass_count", stat_n, 1);
    chk("t1_pass_data", stat_first_data, 32'hCAFE_0123);
    chk("t1_underrun_set", underrun, 1'b1);
    tick(99);
    in_valid = 1'b1;
    in_data  = 32'h5555_AAAA;
    tick(1);
    in_valid = 1'b0;
    chk("t1_slot_full_not_ready", in_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t1_rst_out_data", out_data, 32'h0);
    chk("t1_rst_out_valid", out_valid, 1'b0);
    chk("t1_rst_in_ready", in_ready, 1'b1);
    chk("t1_rst_underrun", underrun, 1'b0);
    chk("t1_rst_resync", resync, 1'b0);
    repeat (2) @(negedge sample_clk);
    reset_n = 1'b1;
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t1_post_no_valid", stat_n, 0);
    chk("t1_post_underrun", underrun, 1'b1);
    chk("t1_post_resync_at", stat_resync_at, 256);
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t1_post_pass_count", stat_n, 1);
    chk("t1_post_hold_zero", stat_first_data, 32'h0);

    // ---------------- T2: 1536k zero-stuff ----------------
    rate_sel  = RATE_1536K;
    hold_mode = 1'b0;
    run_period(256, 1'b1, 32'h1234_8000, 32'h0);
    chk("t2_apply_no_valid", stat_n, 0);
    chk("t2_apply_resync", stat_resync, 1);
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t2_count", stat_n, 32);
    chk("t2_first_at", stat_first, 8);
    chk("t2_first_data", stat_first_data, 32'h1234_8000);
    chk("t2_zero_stuff", stat_other_bad, 0);
    chk("t2_last_at", stat_last, 256);
    chk("t2_no_resync", stat_resync, 0);

    // ---------------- T3: 384k sample-hold ----------------
    rate_sel  = RATE_384K;
    hold_mode = 1'b1;
    run_period(256, 1'b1, 32'h7FFF_FFFE, 32'h0);
    chk("t3_apply_no_valid", stat_n, 0);
    chk("t3_apply_resync_at", stat_resync_at, 256);
    run_period(256, 1'b0, 32'h0, 32'h7FFF_FFFE);
    chk("t3_count", stat_n, 8);
    chk("t3_first_at", stat_first, 32);
    chk("t3_first_data", stat_first_data, 32'h7FFF_FFFE);
    chk("t3_hold_repeat", stat_other_bad, 0);
    chk("t3_last_at", stat_last, 256);

    // ---------------- T4: 12k block average ----------------
    rate_sel = RATE_12K;
    avg_mode = 1'b1;
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t4_apply_no_valid", stat_n, 0);
    chk("t4_apply_resync", stat_resync, 1);
    run_period(256, 1'b1, 32'h0010_0064, 32'h0);
    chk("t4_blk0_no_valid", stat_n, 0);
    run_period(256, 1'b1, 32'h0020_FFFC, 32'h0);
    chk("t4_blk1_no_valid", stat_n, 0);
    run_period(256, 1'b1, 32'h0030_0007, 32'h0);
    chk("t4_blk2_no_valid", stat_n, 0);
    run_period(256, 1'b1, 32'h0040_8001, 32'h0);
    chk("t4_count", stat_n, 1);
    chk("t4_at", stat_first, 256);
    chk("t4_avg", stat_first_data, 32'h0028_E01A);

    // ---------------- T5: back-to-back input at base rate ----------------
    rate_sel  = RATE_48K;
    avg_mode  = 1'b0;
    hold_mode = 1'b0;
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t5_apply_no_valid", stat_n, 0);
    chk("t5_apply_resync_at", stat_resync_at, 256);
    acc_cnt  = 0;
    low_cnt  = 0;
    outs     = 0;
    in_valid = 1'b1;
    in_data  = frame_of(0);
    for (int i = 0; i < 768; i++) begin
      take = in_ready;
      if (take) acc_cnt++;
      else      low_cnt++;
      @(negedge sample_clk);
      if (take) in_data = frame_of(acc_cnt);
      if (out_valid) begin
        exp_seq = (outs == 0) ? 32'h0 : frame_of(outs - 1);
        chk("t5_seq", out_data, exp_seq);
        outs++;
      end
    end
    in_valid = 1'b0;
    chk("t5_accepts", acc_cnt, 4);
    chk("t5_ready_low", low_cnt, 764);
    chk("t5_outputs", outs, 3);

    // ---------------- T6: 768k -> 24k mid-period ----------------
    rate_sel = RATE_768K;
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t6_apply1_no_valid", stat_n, 0);
    chk("t6_apply1_resync_at", stat_resync_at, 256);
    run_period(256, 1'b0, 32'h0, 32'h0);
    chk("t6_r1_count", stat_n, 16);
    chk("t6_r1_first_at", stat_first, 16);
    chk("t6_r1_first_data", stat_first_data, frame_of(3));
    chk("t6_r1_zero_stuff", stat_other_bad, 0);
    tick(100);
    rate_sel = RATE_24K;
    run_period(156, 1'b0, 32'h0, 32'h0);
    chk("t6_suppressed", stat_n, 0);
    chk("t6_resync_count", stat_resync, 1);
    chk("t6_resync_at", stat_resync_at, 156);
    run_period(256, 1'b1, 32'h0001_0002, 32'h0);
    chk("t6_blk_a_no_valid", stat_n, 0);
    chk("t6_blk_a_no_resync", stat_resync, 0);
    run_period(256, 1'b1, 32'h0003_0004, 32'h0);
    chk("t6_blk_b_count", stat_n, 1);
    chk("t6_blk_b_at", stat_first, 256);
    chk("t6_blk_b_data", stat_first_data, 32'h0003_0004);
    run_period(256, 1'b1, 32'h0005_0006, 32'h0);
    chk("t6_blk_c_no_valid", stat_n, 0);
    run_period(256, 1'b1, 32'h0007_0008, 32'h0);
    chk("t6_blk_d_count", stat_n, 1);
    chk("t6_blk_d_data", stat_first_data, 32'h0007_0008);
    chk("t6_underrun_sticky", underrun, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
